mmem_port_arbiter: RTL and testbench
====================================

Name: mmem_port_arbiter

Overview:
- Shares the single byte-wide main-memory port between three requesters:
  - fetch (instruction byte fetch),
  - data (decoder load/store),
  - loader (program/debug loader).
- Round-robin arbitration with registered memory-side outputs.
- Routes read-return strobes back to the requester that issued the read.
- Sits between the instruction receiver / decoder pair and the main memory.

Parameters:
- ADDR_W, 32, width of all address ports.
- RD_LAT, 1, cycles from mem_rden high to mem_rdata valid; legal range 1..4.

Ports:
- clk  input  1  clock, all logic on posedge.
- rst  input  1  synchronous, active-high reset.
- Per requester, with X = f (fetch), d (data), l (loader):
  - X_req  input  1  transfer request; held until granted.
  - X_we  input  1  1 = write, 0 = read.
  - X_addr  input  ADDR_W  byte address.
  - X_wdata  input  8  write byte.
  - X_gnt  output  1  one-cycle pulse: transfer accepted.
  - X_rvalid  output  1  one-cycle pulse: X_rdata valid for this requester's read.
  - X_rdata  output  8  read byte; all three are tied to mem_rdata.
- mem_addr  output  ADDR_W  memory address, registered.
- mem_wdata  output  8  memory write byte, registered.
- mem_wren  output  1  memory write strobe, registered.
- mem_rden  output  1  memory read strobe, registered.
- mem_rdata  input  8  memory read byte, valid RD_LAT cycles after mem_rden.

Behaviour:
- Reset values:
  - all X_gnt, X_rvalid, mem_wren, mem_rden = 0;
  - mem_addr = 0, mem_wdata = 0;
  - round-robin pointer = "last granted loader", so fetch has first priority.
  - The read-return tag pipeline is cleared.
- Arbitration, cycle N:
  - Eligible = X_req high AND X_gnt low in cycle N. A requester is never granted two cycles in a row on the same held request.
  - Winner = first eligible after the last granted, in rotating order f -> d -> l -> f.
- Grant, posedge ending cycle N:
  - Winner's X_gnt = 1 for cycle N+1.
  - mem_addr / mem_wdata are loaded from the winner.
  - mem_wren = winner X_we; mem_rden = !winner X_we.
  - Pointer := winner.
- No eligible requester: mem_wren = mem_rden = 0; mem_addr / mem_wdata hold their last values; pointer unchanged.
- Requester rules:
  - Keep req/we/addr/wdata stable from assertion until the cycle gnt is seen.
  - May drop req or present a new request at the posedge ending the gnt cycle.
- Throughput:
  - One transfer per cycle overall when requests alternate between requesters.
  - One transfer per 2 cycles for a single requester.
- Read return: a read granted in cycle N+1 (mem_rden high) produces the owner's X_rvalid high in cycle N+1+RD_LAT. Tracked by an RD_LAT-deep shift register of {valid, 2-bit owner}.
- Writes never produce rvalid.
- rvalid for one requester may coincide with gnt for another; both are honoured independently.
- Reset mid-operation: in-flight reads are discarded, no rvalid after reset, gnt drops in the cycle after rst is sampled.
- Requests dropped without a grant are simply ignored (no error).

Optional Feature:
- Macro: MMEM_ARB_LOCK_EN.
- With the macro defined:
  - Extra inputs f_lock, d_lock, l_lock (1 bit each).
  - If the requester granted in cycle N+1 has X_lock high in that cycle, it alone stays eligible. The no-back-to-back rule still applies, so it wins the next arbitration after its gnt cycle once it re-requests.
  - Others stall until the owner deasserts lock (checked on each owner grant cycle) or drops req.
  - This lets fetch pull 4 consecutive instruction bytes unbroken.
- Without the macro: no lock ports; pure round-robin.

Test Plan:
1. After reset, f_req=d_req=l_req=1 (reads, addrs 0x10 / 0x20 / 0x30) held continuously, requesters re-requesting immediately:
   - grants in order f, d, l, f, …;
   - mem_addr sequence 0x10, 0x20, 0x30;
   - each X_rvalid exactly RD_LAT cycles after its mem_rden cycle.
2. d write only (d_we=1, addr 0x40, wdata 0xA5):
   - d_gnt one cycle;
   - mem_wren=1, mem_addr=0x40, mem_wdata=0xA5 in the gnt cycle;
   - no d_rvalid ever.
3. Single requester f reading addrs 0..3 back-to-back: f_gnt every other cycle; 4 f_rvalid pulses, returning mem_rdata for 0, 1, 2, 3 in order.
4. RD_LAT=3, f read granted, then rst asserted one cycle later: no f_rvalid appears; all outputs at reset values the cycle after rst is sampled.
5. Idle (all req=0) after a transfer to 0x55: mem_wren=mem_rden=0 and mem_addr holds 0x55 indefinitely.
6. MMEM_ARB_LOCK_EN, f_lock=1 with f issuing 4 reads while d_req=1:
   - no d_gnt until f_lock drops;
   - d granted at the first arbitration after that.

Source files
------------

// File: rtl/mmem_port_arbiter_if.sv
// Bundle for the requester side and the byte-wide memory side of mmem_port_arbiter.
// The lock inputs are present only when MMEM_ARB_LOCK_EN is defined.
interface mmem_port_arbiter_if #(
  parameter int ADDR_W = 32
);
  logic              f_req;
  logic              f_we;
  logic [ADDR_W-1:0] f_addr;
  logic [7:0]        f_wdata;
  logic              f_gnt;
  logic              f_rvalid;
  logic [7:0]        f_rdata;

  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [7:0]        d_wdata;
  logic              d_gnt;
  logic              d_rvalid;
  logic [7:0]        d_rdata;

  logic              l_req;
  logic              l_we;
  logic [ADDR_W-1:0] l_addr;
  logic [7:0]        l_wdata;
  logic              l_gnt;
  logic              l_rvalid;
  logic [7:0]        l_rdata;

`ifdef MMEM_ARB_LOCK_EN
  logic              f_lock;
  logic              d_lock;
  logic              l_lock;
`endif

  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic              mem_wren;
  logic              mem_rden;
  logic [7:0]        mem_rdata;

  modport slave (
`ifdef MMEM_ARB_LOCK_EN
    input  f_lock, d_lock, l_lock,
`endif
    input  f_req, f_we, f_addr, f_wdata,
    input  d_req, d_we, d_addr, d_wdata,
    input  l_req, l_we, l_addr, l_wdata,
    output f_gnt, f_rvalid, f_rdata,
    output d_gnt, d_rvalid, d_rdata,
    output l_gnt, l_rvalid, l_rdata,
    output mem_addr, mem_wdata, mem_wren, mem_rden,
    input  mem_rdata
  );

  modport master (
`ifdef MMEM_ARB_LOCK_EN
    output f_lock, d_lock, l_lock,
`endif
    output f_req, f_we, f_addr, f_wdata,
    output d_req, d_we, d_addr, d_wdata,
    output l_req, l_we, l_addr, l_wdata,
    input  f_gnt, f_rvalid, f_rdata,
    input  d_gnt, d_rvalid, d_rdata,
    input  l_gnt, l_rvalid, l_rdata,
    input  mem_addr, mem_wdata, mem_wren, mem_rden,
    output mem_rdata
  );
endinterface

// File: rtl/mmem_port_arbiter.sv
// Round-robin arbiter sharing one byte-wide memory port between fetch, data and loader,
// with read-return routing. Define MMEM_ARB_LOCK_EN to enable per-requester port locking.
module mmem_port_arbiter #(
  parameter int ADDR_W = 32,
  parameter int RD_LAT = 1
) (
  input logic                clk,
  input logic                rst,
  mmem_port_arbiter_if.slave bus
);
  localparam logic [1:0] ID_F = 2'd0;
  localparam logic [1:0] ID_D = 2'd1;
  localparam logic [1:0] ID_L = 2'd2;

  logic [2:0]        req_s;
  logic [2:0]        elig_s;
  logic [2:0]        gnt_q, gnt_d;
  logic [1:0]        ptr_q, ptr_d;
  logic [1:0]        win_s, cand_s;
  logic              win_vld_s;
  logic              lock_now_s;
  logic [ADDR_W-1:0] win_addr_s;
  logic [7:0]        win_wdata_s;
  logic              win_we_s;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [7:0]        mem_wdata_q, mem_wdata_d;
  logic              mem_wren_q, mem_wren_d;
  logic              mem_rden_q, mem_rden_d;
  logic [2:0]        tag_q [RD_LAT];
  logic [2:0]        tag_out_s;

  function automatic logic [1:0] rr_next(input logic [1:0] id);
    case (id)
      ID_F:    rr_next = ID_D;
      ID_D:    rr_next = ID_L;
      default: rr_next = ID_F;
    endcase
  endfunction

  assign req_s = {bus.l_req, bus.d_req, bus.f_req};

`ifdef MMEM_ARB_LOCK_EN
  logic [2:0] lock_s;
  logic       locked_q;

  assign lock_s = {bus.l_lock, bus.d_lock, bus.f_lock};

  // ptr_q is the current owner; lock is re-evaluated on each of its grant cycles.
  always_comb begin
    if (gnt_q != 3'b000) begin
      lock_now_s = lock_s[ptr_q];
    end else begin
      lock_now_s = locked_q & req_s[ptr_q];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      locked_q <= 1'b0;
    end else begin
      locked_q <= lock_now_s;
    end
  end
`else
  assign lock_now_s = 1'b0;
`endif

  assign elig_s = req_s & ~gnt_q & (lock_now_s ? (3'b001 << ptr_q) : 3'b111);

  // Rotating search starting just after the last granted requester.
  always_comb begin
    win_vld_s = 1'b0;
    win_s     = ptr_q;
    cand_s    = ptr_q;
    for (int k = 0; k < 3; k++) begin
      cand_s = rr_next(cand_s);
      if (!win_vld_s && elig_s[cand_s]) begin
        win_vld_s = 1'b1;
        win_s     = cand_s;
      end else begin
        win_s     = win_s;
      end
    end
  end

  always_comb begin
    case (win_s)
      ID_F: begin
        win_addr_s  = bus.f_addr;
        win_wdata_s = bus.f_wdata;
        win_we_s    = bus.f_we;
      end
      ID_D: begin
        win_addr_s  = bus.d_addr;
        win_wdata_s = bus.d_wdata;
        win_we_s    = bus.d_we;
      end
      default: begin
        win_addr_s  = bus.l_addr;
        win_wdata_s = bus.l_wdata;
        win_we_s    = bus.l_we;
      end
    endcase
  end

  always_comb begin
    gnt_d       = 3'b000;
    ptr_d       = ptr_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_wren_d  = 1'b0;
    mem_rden_d  = 1'b0;
    if (win_vld_s) begin
      gnt_d       = 3'b001 << win_s;
      ptr_d       = win_s;
      mem_addr_d  = win_addr_s;
      mem_wdata_d = win_wdata_s;
      mem_wren_d  = win_we_s;
      mem_rden_d  = ~win_we_s;
    end else begin
      ptr_d       = ptr_q;
    end
  end

  // Pointer resets to the loader so that fetch has first priority.
  always_ff @(posedge clk) begin
    if (rst) begin
      gnt_q       <= 3'b000;
      ptr_q       <= ID_L;
      mem_addr_q  <= {ADDR_W{1'b0}};
      mem_wdata_q <= 8'h00;
      mem_wren_q  <= 1'b0;
      mem_rden_q  <= 1'b0;
    end else begin
      gnt_q       <= gnt_d;
      ptr_q       <= ptr_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_wren_q  <= mem_wren_d;
      mem_rden_q  <= mem_rden_d;
    end
  end

  // During the rden cycle ptr_q still names the read's owner.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < RD_LAT; k++) begin
        tag_q[k] <= 3'b000;
      end
    end else begin
      tag_q[0] <= {mem_rden_q, ptr_q};
      for (int k = 1; k < RD_LAT; k++) begin
        tag_q[k] <= tag_q[k-1];
      end
    end
  end

  assign tag_out_s = tag_q[RD_LAT-1];

  assign bus.f_gnt     = gnt_q[0];
  assign bus.d_gnt     = gnt_q[1];
  assign bus.l_gnt     = gnt_q[2];
  assign bus.f_rvalid  = tag_out_s[2] && (tag_out_s[1:0] == ID_F);
  assign bus.d_rvalid  = tag_out_s[2] && (tag_out_s[1:0] == ID_D);
  assign bus.l_rvalid  = tag_out_s[2] && (tag_out_s[1:0] == ID_L);
  assign bus.f_rdata   = bus.mem_rdata;
  assign bus.d_rdata   = bus.mem_rdata;
  assign bus.l_rdata   = bus.mem_rdata;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.mem_wren  = mem_wren_q;
  assign bus.mem_rden  = mem_rden_q;
endmodule

// File: tb/tb_mmem_port_arbiter.sv
// Scoreboard bench for mmem_port_arbiter: two instances (RD_LAT=1 and RD_LAT=3) share
// one directed stimulus stream; expected grants and read returns are queued per instance.
`timescale 1ns/1ps
module tb_mmem_port_arbiter;
  localparam int AW = 32;

  typedef struct packed {
    logic [1:0]  who;
    logic        we;
    logic [31:0] addr;
    logic [7:0]  data;
    logic [31:0] cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  int unsigned cyc = 0;
  int          total = 0;
  int          passed = 0;
  exp_t        gq [2][$];
  exp_t        rq [2][$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mmem_port_arbiter_if #(.ADDR_W(AW)) bus1 ();
  mmem_port_arbiter_if #(.ADDR_W(AW)) bus3 ();

  mmem_port_arbiter #(.ADDR_W(AW), .RD_LAT(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));
  mmem_port_arbiter #(.ADDR_W(AW), .RD_LAT(3)) dut3 (.clk(clk), .rst(rst), .bus(bus3.slave));

  assign bus3.f_req = bus1.f_req;  assign bus3.f_we = bus1.f_we;
  assign bus3.f_addr = bus1.f_addr; assign bus3.f_wdata = bus1.f_wdata;
  assign bus3.d_req = bus1.d_req;  assign bus3.d_we = bus1.d_we;
  assign bus3.d_addr = bus1.d_addr; assign bus3.d_wdata = bus1.d_wdata;
  assign bus3.l_req = bus1.l_req;  assign bus3.l_we = bus1.l_we;
  assign bus3.l_addr = bus1.l_addr; assign bus3.l_wdata = bus1.l_wdata;
`ifdef MMEM_ARB_LOCK_EN
  assign bus3.f_lock = bus1.f_lock;
  assign bus3.d_lock = bus1.d_lock;
  assign bus3.l_lock = bus1.l_lock;
`endif

  function automatic logic [7:0] memf(input logic [AW-1:0] a);
    return a[7:0] ^ 8'h5A;
  endfunction

  // Memory models: read data appears RD_LAT cycles after the rden cycle.
  logic [7:0] rd1_q;
  logic [7:0] rd3_q [3];
  always @(posedge clk) begin
    rd1_q    <= bus1.mem_rden ? memf(bus1.mem_addr) : 8'h00;
    rd3_q[0] <= bus3.mem_rden ? memf(bus3.mem_addr) : 8'h00;
    rd3_q[1] <= rd3_q[0];
    rd3_q[2] <= rd3_q[1];
  end
  assign bus1.mem_rdata = rd1_q;
  assign bus3.mem_rdata = rd3_q[2];

  logic [2:0]    gnt_w [2];
  logic [2:0]    rv_w [2];
  logic [AW-1:0] maddr_w [2];
  logic [7:0]    mwd_w [2];
  logic          wren_w [2];
  logic          rden_w [2];
  logic [7:0]    rdat_w [2][3];

  assign gnt_w[0] = {bus1.l_gnt, bus1.d_gnt, bus1.f_gnt};
  assign gnt_w[1] = {bus3.l_gnt, bus3.d_gnt, bus3.f_gnt};
  assign rv_w[0]  = {bus1.l_rvalid, bus1.d_rvalid, bus1.f_rvalid};
  assign rv_w[1]  = {bus3.l_rvalid, bus3.d_rvalid, bus3.f_rvalid};
  assign maddr_w[0] = bus1.mem_addr;  assign maddr_w[1] = bus3.mem_addr;
  assign mwd_w[0]   = bus1.mem_wdata; assign mwd_w[1]   = bus3.mem_wdata;
  assign wren_w[0]  = bus1.mem_wren;  assign wren_w[1]  = bus3.mem_wren;
  assign rden_w[0]  = bus1.mem_rden;  assign rden_w[1]  = bus3.mem_rden;
  assign rdat_w[0][0] = bus1.f_rdata; assign rdat_w[0][1] = bus1.d_rdata; assign rdat_w[0][2] = bus1.l_rdata;
  assign rdat_w[1][0] = bus3.f_rdata; assign rdat_w[1][1] = bus3.d_rdata; assign rdat_w[1][2] = bus3.l_rdata;

  // Monitor: every grant/strobe and every rvalid pops and checks one expectation.
  always @(negedge clk) begin : mon
    exp_t e;
    logic ok;
    for (int k = 0; k < 2; k++) begin
      if (gnt_w[k] != 3'b000 || wren_w[k] || rden_w[k]) begin
        if (gq[k].size() == 0) begin
          total++;
          $display("FAIL grant_unexpected dut%0d cyc=%0d gnt=%b wren=%b rden=%b addr=%h required no transfer",
                   k, cyc, gnt_w[k], wren_w[k], rden_w[k], maddr_w[k]);
        end else begin
          e  = gq[k].pop_front();
          ok = (gnt_w[k] == (3'b001 << e.who)) && (cyc == e.cyc) && (maddr_w[k] == e.addr) &&
               (wren_w[k] == e.we) && (rden_w[k] == !e.we) && (!e.we || mwd_w[k] == e.data);
          total++;
          if (ok) passed++;
          else $display("FAIL grant dut%0d actual cyc=%0d gnt=%b addr=%h wd=%h wren=%b rden=%b required cyc=%0d gnt=%b addr=%h wd=%h we=%b",
                        k, cyc, gnt_w[k], maddr_w[k], mwd_w[k], wren_w[k], rden_w[k],
                        e.cyc, 3'b001 << e.who, e.addr, e.data, e.we);
        end
      end
      if (rv_w[k] != 3'b000) begin
        if (rq[k].size() == 0) begin
          total++;
          $display("FAIL rvalid_unexpected dut%0d cyc=%0d rvalid=%b required none", k, cyc, rv_w[k]);
        end else begin
          e  = rq[k].pop_front();
          ok = (rv_w[k] == (3'b001 << e.who)) && (cyc == e.cyc) && (rdat_w[k][e.who] == e.data);
          total++;
          if (ok) passed++;
          else $display("FAIL rvalid dut%0d actual cyc=%0d rvalid=%b rdata=%h required cyc=%0d rvalid=%b rdata=%h",
                        k, cyc, rv_w[k], rdat_w[k][e.who], e.cyc, 3'b001 << e.who, e.data);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act === req) passed++;
    else $display("FAIL %s actual=%h required=%h", name, act, req);
  endtask

  function automatic logic [63:0] snap(input int k);
    return {16'd0, gnt_w[k], rv_w[k], wren_w[k], rden_w[k], maddr_w[k], mwd_w[k]};
  endfunction

  task automatic wait_cyc(input int unsigned n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic exp_xfer(input logic [1:0] who, input logic we, input logic [31:0] a,
                          input logic [7:0] wd, input int unsigned g, input bit rv1, input bit rv3);
    exp_t e;
    e.who = who; e.we = we; e.addr = a; e.data = wd; e.cyc = g;
    gq[0].push_back(e);
    gq[1].push_back(e);
    e.data = memf(a);
    if (!we && rv1) begin e.cyc = g + 1; rq[0].push_back(e); end
    if (!we && rv3) begin e.cyc = g + 3; rq[1].push_back(e); end
  endtask

  task automatic drive(input logic [1:0] who, input logic r, input logic we,
                       input logic [31:0] a, input logic [7:0] wd);
    case (who)
      2'd0: begin bus1.f_req = r; bus1.f_we = we; bus1.f_addr = a; bus1.f_wdata = wd; end
      2'd1: begin bus1.d_req = r; bus1.d_we = we; bus1.d_addr = a; bus1.d_wdata = wd; end
      default: begin bus1.l_req = r; bus1.l_we = we; bus1.l_addr = a; bus1.l_wdata = wd; end
    endcase
  endtask

  initial begin : stim
    int unsigned t;
    exp_t e;
    for (int w = 0; w < 3; w++) drive(w[1:0], 1'b0, 1'b0, 32'h0, 8'h00);
`ifdef MMEM_ARB_LOCK_EN
    bus1.f_lock = 1'b0; bus1.d_lock = 1'b0; bus1.l_lock = 1'b0;
`endif
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("reset_state_lat1", snap(0), 64'd0);
    chk("reset_state_lat3", snap(1), 64'd0);

    // All three reading continuously: f, d, l, f, d, l.
    @(posedge clk); #1;
    t = cyc;
    drive(2'd0, 1'b1, 1'b0, 32'h10, 8'h00);
    drive(2'd1, 1'b1, 1'b0, 32'h20, 8'h00);
    drive(2'd2, 1'b1, 1'b0, 32'h30, 8'h00);
    for (int r = 0; r < 2; r++) begin
      exp_xfer(2'd0, 1'b0, 32'h10, 8'h00, t + 1 + 3*r, 1'b1, 1'b1);
      exp_xfer(2'd1, 1'b0, 32'h20, 8'h00, t + 2 + 3*r, 1'b1, 1'b1);
      exp_xfer(2'd2, 1'b0, 32'h30, 8'h00, t + 3 + 3*r, 1'b1, 1'b1);
    end
    wait_cyc(t + 6);
    for (int w = 0; w < 3; w++) drive(w[1:0], 1'b0, 1'b0, 32'h0, 8'h00);

    // Single data write: no rvalid may follow.
    wait_cyc(t + 12);
    t = cyc;
    drive(2'd1, 1'b1, 1'b1, 32'h40, 8'hA5);
    exp_xfer(2'd1, 1'b1, 32'h40, 8'hA5, t + 1, 1'b0, 1'b0);
    wait_cyc(t + 2);
    drive(2'd1, 1'b0, 1'b0, 32'h0, 8'h00);

    // Lone fetch reading 0..3: one grant every other cycle.
    wait_cyc(t + 6);
    t = cyc;
    for (int i = 0; i < 4; i++) begin
      wait_cyc(t + 2*i);
      drive(2'd0, 1'b1, 1'b0, i, 8'h00);
      exp_xfer(2'd0, 1'b0, i, 8'h00, t + 2*i + 1, 1'b1, 1'b1);
    end
    wait_cyc(t + 8);
    drive(2'd0, 1'b0, 1'b0, 32'h0, 8'h00);

    // Write to 0x55, then idle: address and data must hold, strobes low.
    wait_cyc(t + 12);
    t = cyc;
    drive(2'd0, 1'b1, 1'b1, 32'h55, 8'h3C);
    exp_xfer(2'd0, 1'b1, 32'h55, 8'h3C, t + 1, 1'b0, 1'b0);
    wait_cyc(t + 2);
    drive(2'd0, 1'b0, 1'b0, 32'h0, 8'h00);
    for (int i = 0; i < 3; i++) begin
      wait_cyc(t + 4 + 2*i);
      #1;
      chk("idle_hold_lat1", {22'd0, wren_w[0], rden_w[0], maddr_w[0], mwd_w[0]}, {22'd0, 2'b00, 32'h55, 8'h3C});
      chk("idle_hold_lat3", {22'd0, wren_w[1], rden_w[1], maddr_w[1], mwd_w[1]}, {22'd0, 2'b00, 32'h55, 8'h3C});
    end

    // Read granted, reset one cycle later: only the RD_LAT=1 return escapes.
    wait_cyc(t + 12);
    t = cyc;
    drive(2'd0, 1'b1, 1'b0, 32'h07, 8'h00);
    exp_xfer(2'd0, 1'b0, 32'h07, 8'h00, t + 1, 1'b1, 1'b0);
    wait_cyc(t + 2);
    drive(2'd0, 1'b0, 1'b0, 32'h0, 8'h00);
    rst = 1'b1;
    wait_cyc(t + 3);
    rst = 1'b0;
    #1;
    chk("mid_reset_lat1", snap(0), 64'd0);
    chk("mid_reset_lat3", snap(1), 64'd0);

`ifdef MMEM_ARB_LOCK_EN
    // Locked fetch burst of 4 while data waits.
    wait_cyc(t + 10);
    t = cyc;
    bus1.f_lock = 1'b1;
    drive(2'd0, 1'b1, 1'b0, 32'h80, 8'h00);
    drive(2'd1, 1'b1, 1'b0, 32'h90, 8'h00);
    for (int i = 0; i < 4; i++) exp_xfer(2'd0, 1'b0, 32'h80 + i, 8'h00, t + 1 + 2*i, 1'b1, 1'b1);
    exp_xfer(2'd1, 1'b0, 32'h90, 8'h00, t + 8, 1'b1, 1'b1);
    for (int i = 1; i < 4; i++) begin
      wait_cyc(t + 2*i);
      drive(2'd0, 1'b1, 1'b0, 32'h80 + i, 8'h00);
      if (i == 3) bus1.f_lock = 1'b0;
    end
    wait_cyc(t + 8);
    drive(2'd0, 1'b0, 1'b0, 32'h0, 8'h00);
    wait_cyc(t + 9);
    drive(2'd1, 1'b0, 1'b0, 32'h0, 8'h00);
`endif

    wait_cyc(t + 16);
    for (int k = 0; k < 2; k++) begin
      while (gq[k].size() > 0) begin
        e = gq[k].pop_front();
        total++;
        $display("FAIL grant_missing dut%0d actual none required cyc=%0d who=%0d addr=%h", k, e.cyc, e.who, e.addr);
      end
      while (rq[k].size() > 0) begin
        e = rq[k].pop_front();
        total++;
        $display("FAIL rvalid_missing dut%0d actual none required cyc=%0d who=%0d data=%h", k, e.cyc, e.who, e.data);
      end
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end
endmodule
